// File: rtl/cpu_defs.sv
// Shared CPU definitions: register/RoB encodings and the commit sequencer state set.
package cpu_defs;

  localparam logic [5:0] NON_REG   = 6'b100000;
  localparam logic [7:0] NON_DEP   = 8'hFF;

  localparam logic [1:0] TYPE_ALU  = 2'b00;
  localparam logic [1:0] TYPE_BR   = 2'b01;
  localparam logic [1:0] TYPE_ST   = 2'b10;
  localparam logic [1:0] TYPE_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_STORE_WAIT = 2'b01,
    ST_FLUSH      = 2'b10,
    ST_HALT       = 2'b11
  } cc_state_e;

endpackage

// File: rtl/commit_controller.sv
// In-order retirement sequencer: drives the register-file commit port from the RoB head,
// sequences stores through the LSB, turns mispredicts into a one-cycle flush, latches halt.
module commit_controller
  import cpu_defs::*;
#(
  parameter int                         REG_WIDTH    = 5,
  parameter int                         EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0]    NON_REG      = cpu_defs::NON_REG,
  parameter int                         RoB_WIDTH    = 8
) (
  input  logic                     Sys_clk,
  input  logic                     Sys_rst,
  input  logic                     Sys_rdy,
  input  logic                     RoBCC_valid,
  input  logic                     RoBCC_ready,
  input  logic [RoB_WIDTH-1:0]     RoBCC_index,
  input  logic [1:0]               RoBCC_type,
  input  logic [EX_REG_WIDTH-1:0]  RoBCC_rd,
  input  logic [31:0]              RoBCC_value,
  input  logic                     RoBCC_mispredict,
  input  logic [31:0]              RoBCC_target,
  output logic                     CCRoB_pop,
  output logic                     CCRF_en,
  output logic                     CCRF_pre_judge,
  output logic [RoB_WIDTH-1:0]     CCRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0]  CCRF_rd,
  output logic [31:0]              CCRF_value,
  output logic                     CCLSB_store_en,
  output logic [RoB_WIDTH-1:0]     CCLSB_RoB_index,
  input  logic                     LSBCC_store_done,
  output logic                     CC_flush,
  output logic [31:0]              CCIF_target,
  output logic                     CC_halt,
  output logic [31:0]              CC_commit_cnt
);

  cc_state_e                r_state;
  cc_state_e                w_state_nxt;

  logic                     r_pop,       w_pop;
  logic                     r_rf_en,     w_rf_en;
  logic                     r_pre_judge, w_pre_judge;
  logic [RoB_WIDTH-1:0]     r_rf_idx,    w_rf_idx;
  logic [EX_REG_WIDTH-1:0]  r_rf_rd,     w_rf_rd;
  logic [31:0]              r_rf_value,  w_rf_value;
  logic                     r_st_en,     w_st_en;
  logic [RoB_WIDTH-1:0]     r_lsb_idx,   w_lsb_idx;
  logic                     r_flush,     w_flush;
  logic [31:0]              r_target,    w_target;
  logic                     r_halt,      w_halt;
  logic [31:0]              r_cnt,       w_cnt;

  logic                     w_eligible;
  logic [EX_REG_WIDTH-1:0]  w_head_rd;

  // A head shown during a pop or flush cycle is stale, so it is not examined.
  assign w_eligible = Sys_rdy & RoBCC_valid & RoBCC_ready & ~r_pop & ~r_flush;
  assign w_head_rd  = {RoBCC_rd[EX_REG_WIDTH-1:REG_WIDTH], RoBCC_rd[REG_WIDTH-1:0]};

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rf_en     = 1'b0;
    w_st_en     = 1'b0;
    w_flush     = 1'b0;
    w_pre_judge = 1'b1;
    w_rf_idx    = r_rf_idx;
    w_rf_rd     = r_rf_rd;
    w_rf_value  = r_rf_value;
    w_lsb_idx   = r_lsb_idx;
    w_target    = r_target;
    w_halt      = r_halt;
    w_cnt       = r_cnt;
    if (Sys_rdy) begin
      case (r_state)
        ST_RUN: begin
          if (w_eligible) begin
            case (RoBCC_type)
              TYPE_ALU, TYPE_BR: begin
                w_pop      = 1'b1;
                w_rf_en    = 1'b1;
                w_rf_idx   = RoBCC_index;
                w_rf_rd    = w_head_rd;
                w_rf_value = RoBCC_value;
                w_cnt      = r_cnt + 32'd1;
                if ((RoBCC_type == TYPE_BR) && RoBCC_mispredict) begin
                  w_target    = RoBCC_target;
                  w_state_nxt = ST_FLUSH;
                end else begin
                  w_state_nxt = ST_RUN;
                end
              end
              TYPE_ST: begin
                w_st_en     = 1'b1;
                w_lsb_idx   = RoBCC_index;
                w_state_nxt = ST_STORE_WAIT;
              end
              TYPE_HALT: begin
                w_pop       = 1'b1;
                w_halt      = 1'b1;
                w_cnt       = r_cnt + 32'd1;
                w_state_nxt = ST_HALT;
              end
              default: w_state_nxt = ST_RUN;
            endcase
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        // A done that coincides with our own store_en pulse belongs to nothing yet.
        ST_STORE_WAIT: begin
          if (LSBCC_store_done && !r_st_en) begin
            w_pop       = 1'b1;
            w_cnt       = r_cnt + 32'd1;
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_STORE_WAIT;
          end
        end
        ST_FLUSH: begin
          w_flush     = 1'b1;
          w_pre_judge = 1'b0;
          w_state_nxt = ST_RUN;
        end
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_RUN;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_pop       <= 1'b0;
      r_rf_en     <= 1'b0;
      r_pre_judge <= 1'b1;
      r_rf_idx    <= '0;
      r_rf_rd     <= NON_REG;
      r_rf_value  <= 32'd0;
      r_st_en     <= 1'b0;
      r_lsb_idx   <= '0;
      r_flush     <= 1'b0;
      r_target    <= 32'd0;
      r_halt      <= 1'b0;
      r_cnt       <= 32'd0;
    end else begin
      r_pop       <= w_pop;
      r_rf_en     <= w_rf_en;
      r_pre_judge <= w_pre_judge;
      r_rf_idx    <= w_rf_idx;
      r_rf_rd     <= w_rf_rd;
      r_rf_value  <= w_rf_value;
      r_st_en     <= w_st_en;
      r_lsb_idx   <= w_lsb_idx;
      r_flush     <= w_flush;
      r_target    <= w_target;
      r_halt      <= w_halt;
      r_cnt       <= w_cnt;
    end
  end

  assign CCRoB_pop       = r_pop;
  assign CCRF_en         = r_rf_en;
  assign CCRF_pre_judge  = r_pre_judge;
  assign CCRF_RoB_index  = r_rf_idx;
  assign CCRF_rd         = r_rf_rd;
  assign CCRF_value      = r_rf_value;
  assign CCLSB_store_en  = r_st_en;
  assign CCLSB_RoB_index = r_lsb_idx;
  assign CC_flush        = r_flush;
  assign CCIF_target     = r_target;
  assign CC_halt         = r_halt;
  assign CC_commit_cnt   = r_cnt;

endmodule

// File: doc/commit_controller.md
# commit_controller

In-order retirement sequencer between the RoB head and the register file. Each cycle it inspects the RoB head entry and, when the entry is ready, drives the register-file commit port: `CCRF_en`, `CCRF_pre_judge`, index, rd and value. It pops the head, hands stores to the LSB and waits for completion, and turns a branch mispredict into an rd write followed by a one-cycle flush. It also counts retired instructions and latches halt.

## Interface
Parameters:
- `REG_WIDTH`, 5, architectural register index width
- `EX_REG_WIDTH`, 6, extended rd width; MSB set means no register
- `NON_REG`, 6'b100000, "no destination" encoding
- `RoB_WIDTH`, 8, RoB index width

Ports:
- `Sys_clk`  in  1  single clock, rising edge
- `Sys_rst`  in  1  asynchronous, active-high reset
- `Sys_rdy`  in  1  global enable; low freezes all state
- `RoBCC_valid`  in  1  RoB non-empty; head fields valid
- `RoBCC_ready`  in  1  head result available
- `RoBCC_index`  in  RoB_WIDTH  head RoB index
- `RoBCC_type`  in  2  00 ALU/load, 01 branch/jump, 10 store, 11 halt
- `RoBCC_rd`  in  EX_REG_WIDTH  head destination
- `RoBCC_value`  in  32  head result (link value for jumps)
- `RoBCC_mispredict`  in  1  branch resolved opposite to prediction
- `RoBCC_target`  in  32  correct PC for mispredict
- `CCRoB_pop`  out  1  pulse: RoB advances head at end of this cycle
- `CCRF_en`  out  1  pulse: register-file commit valid
- `CCRF_pre_judge`  out  1  0 only during flush cycle
- `CCRF_RoB_index`  out  RoB_WIDTH  committed index
- `CCRF_rd`  out  EX_REG_WIDTH  committed rd
- `CCRF_value`  out  32  committed value
- `CCLSB_store_en`  out  1  pulse: execute store at `CCLSB_RoB_index`
- `CCLSB_RoB_index`  out  RoB_WIDTH  store index
- `LSBCC_store_done`  in  1  store written to memory
- `CC_flush`  out  1  pulse: global pipeline flush
- `CCIF_target`  out  32  redirect PC, valid with `CC_flush`
- `CC_halt`  out  1  sticky halt
- `CC_commit_cnt`  out  32  retired-instruction count

## Operation
- All outputs are registered.
- Reset values: pulses 0, `CCRF_pre_judge` 1, `CCRF_rd` NON_REG, index/value/target 0, `CC_halt` 0, `CC_commit_cnt` 0, state RUN.
- States: RUN, STORE_WAIT, FLUSH, HALT.
- A head entry is eligible when `Sys_rdy && RoBCC_valid && RoBCC_ready && !CCRoB_pop`. The head is ignored during a pop cycle, because it still shows the old entry.
- RUN, eligible, type 00: next cycle `CCRF_en`=1, `CCRoB_pop`=1, fields copied, count+1.
- RUN, eligible, type 01, no mispredict: same as type 00. The register file ignores rd NON_REG and x0.
- RUN, eligible, type 01, mispredict: same as type 00, and the next state is FLUSH. The rd write therefore lands with `pre_judge`=1 before the flush.
- FLUSH: exactly one cycle with `CCRF_pre_judge`=0, `CC_flush`=1, `CCIF_target` = latched target; no pop and no `CCRF_en`. The state then returns to RUN.
- RUN, eligible, type 10: `CCLSB_store_en` pulses for one cycle with the index, then the state moves to STORE_WAIT.
- STORE_WAIT, `LSBCC_store_done`: `CCRoB_pop`=1, count+1, `CCRF_en`=0, then RUN. `store_done` in any other state is ignored.
- RUN, eligible, type 11: `CCRoB_pop`=1, count+1, `CC_halt` set, state HALT. HALT is absorbing until reset.
- `Sys_rdy` low: state, count and latched fields hold, and all pulse outputs are 0 that cycle.
- `CC_commit_cnt` wraps modulo 2^32.

## Timing
- Head eligible at edge N produces commit outputs high during cycle N+1. The RoB updates its head at edge N+2, so peak throughput is one commit per 2 cycles.
- Mispredict: commit in cycle N+1, flush in cycle N+2. The next eligible check is at edge N+3.
- Store: `store_en` in cycle N+1. `store_done` sampled at edge M produces the pop in cycle M+1. A `store_done` that coincides with `store_en` is not counted.
- Asynchronous reset mid-STORE_WAIT or mid-FLUSH returns all outputs to their reset values immediately; no pending pop or flush is emitted.

## Structure
- Shared package `cpu_defs`: `NON_REG`, `NON_DEP`, RoB type encodings (`TYPE_ALU`, `TYPE_BR`, `TYPE_ST`, `TYPE_HALT`), state enum.
- Single flat module; no sub-module is needed.

## Test plan
- Reset: all outputs at reset values; `pre_judge`=1, `CCRF_rd`=6'h20.
- ALU head idx 3, rd 5, value 0x1234, ready: cycle+1 `CCRF_en`=`pop`=1, rd 5, value 0x1234, count 1; no re-commit next cycle.
- Mispredict jalr idx 7, rd 1, value 0x40, target 0x100: cycle+1 `CCRF_en`=1 rd 1 `pre_judge`=1; cycle+2 `pre_judge`=0, `flush`=1, target 0x100.
- Store idx 9: `store_en`=1 idx 9; `store_done` after 5 cycles produces the pop one cycle later with `CCRF_en`=0; spurious `store_done` in RUN is ignored.
- Halt head: pop, `CC_halt`=1 sticky; later ready heads are never popped.
- `Sys_rdy` low while a head is ready: no pulses; commit proceeds after `Sys_rdy` rises. Reset asserted in FLUSH: `flush`=0 at once.
